// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: instruction-memory req/gnt + in-order rvalid bus
interface instr_fetch_queue_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC, imem fetch, prefetch FIFO and IF->ID register; IFQ_PERF_CNT_EN adds perf_fetched/perf_flushed
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pcSrc,
    input  logic [31:0]                branchPC,
    input  logic                       en_pc,
    input  logic                       en_IF,
    instr_fetch_queue_if.master        imem,
    output logic                       id_valid,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_instr
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_flushed
`endif
);
    localparam int FW = $clog2(DEPTH);
    localparam int CW = FW + 1;
    localparam int AW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic [31:0] pc;
    logic [31:0] fifo_pc [DEPTH];
    logic [31:0] fifo_instr [DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0] aq [MAX_OUT];
    logic [AW-1:0] aq_wr, aq_rd;
    logic [OW-1:0] outstanding, drop, out_next;
    logic grant, resp, push, pop;
    // Counting outstanding against FIFO space guarantees every response has a slot.
    always_comb begin
        imem.req = en_pc & ~pcSrc & (32'(count) + 32'(outstanding) < 32'(DEPTH))
                   & (32'(outstanding) < 32'(MAX_OUT));
        imem.addr = pc;
        grant = imem.req & imem.gnt;
        resp = imem.rvalid & (outstanding != '0);
        push = resp & (drop == '0) & ~pcSrc;
        pop = en_IF & (count != '0) & ~pcSrc;
        out_next = outstanding + OW'(grant) - OW'(resp);
    end
    always_ff @(posedge clk) begin
        if (grant) aq[aq_wr] <= pc;
        if (push) begin
            fifo_pc[wr_ptr] <= aq[aq_rd];
            fifo_instr[wr_ptr] <= imem.rdata;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            aq_wr <= '0;
            aq_rd <= '0;
            outstanding <= '0;
            drop <= '0;
            id_valid <= 1'b0;
            id_pc <= '0;
            id_instr <= NOP;
        end else begin
            outstanding <= out_next;
            if (grant) aq_wr <= (aq_wr == AW'(MAX_OUT - 1)) ? '0 : aq_wr + 1'b1;
            if (resp) aq_rd <= (aq_rd == AW'(MAX_OUT - 1)) ? '0 : aq_rd + 1'b1;
            if (pcSrc) pc <= branchPC & ~32'd3;
            else if (grant) pc <= pc + 32'd4;
            // On redirect every request still in flight (after this cycle's response) is stale.
            drop <= pcSrc ? out_next : drop - OW'(resp & (drop != '0));
            if (pcSrc) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
            if (pcSrc || (en_IF && count == '0)) begin
                id_valid <= 1'b0;
                id_instr <= NOP;
            end else if (en_IF) begin
                id_valid <= 1'b1;
                id_pc <= fifo_pc[rd_ptr];
                id_instr <= fifo_instr[rd_ptr];
            end
        end
    end
`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + (pcSrc ? 32'(count) : 32'd0)
                            + 32'(resp & (pcSrc | (drop != '0)));
        end
    end
`endif
    assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: random bus/control stimulus against a program-order stream scoreboard
module tb_instr_fetch_queue;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pcSrc = 1'b0;
    logic en_pc = 1'b0;
    logic en_IF = 1'b0;
    logic [31:0] branchPC = '0;
    logic id_valid;
    logic [31:0] id_pc, id_instr;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif
    instr_fetch_queue_if imem ();
    instr_fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk),
        .rst(rst),
        .pcSrc(pcSrc),
        .branchPC(branchPC),
        .en_pc(en_pc),
        .en_IF(en_IF),
        .imem(imem),
        .id_valid(id_valid),
        .id_pc(id_pc),
        .id_instr(id_instr)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] a;
        int          t;
    } pend_t;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int responses = 0;
    int delivered = 0;
    int total_delivered = 0;
    logic [31:0] exp_q[$];
    pend_t pend[$];
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16]};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Expected program order: consecutive words from the last reset/redirect target.
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(4 * i));
    endtask
    task automatic step(input logic e_pc, input logic e_if, input logic ps, input logic [31:0] bpc,
                        input int gp, input int rp, output logic req_seen);
        logic g, rv;
        logic [31:0] ga;
        int t;
        @(negedge clk);
        en_pc = e_pc;
        en_IF = e_if;
        pcSrc = ps;
        branchPC = bpc;
        if (ps) load_stream(bpc & ~32'd3);
        imem.gnt = $urandom_range(99) < gp;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        if (pend.size() > 0 && pend[0].t < cyc && $urandom_range(99) < rp) begin
            imem.rvalid = 1'b1;
            imem.rdata = mem(pend[0].a);
        end
        #1;
        req_seen = imem.req;
        if (ps) check("redirect_no_req", imem.req, 1'b0);
        if (imem.req) check("max_outstanding", pend.size() < MAX_OUT, 1'b1);
        g = imem.req & imem.gnt;
        ga = imem.addr;
        rv = imem.rvalid;
        t = cyc;
        @(posedge clk);
        if (rv) begin
            void'(pend.pop_front());
            responses++;
        end
        if (g) pend.push_back('{ga, t});
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en_pc = 1'b0;
        en_IF = 1'b0;
        pcSrc = 1'b0;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        load_stream(RST_PC);
        pend.delete();
        responses = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_addr", imem.addr, RST_PC);
        check("reset_req", imem.req, 1'b0);
        @(negedge clk);
        imem.rvalid = 1'b0;
    endtask
    initial begin
        logic r_rst, r_ps, r_if, r_req, r_gnt, p_req, p_gnt, p_rst, m_v;
        logic [31:0] r_addr, p_addr, m_pc, m_instr, e;
        p_req = 1'b0;
        p_gnt = 1'b0;
        p_rst = 1'b1;
        p_addr = '0;
        m_v = 1'b0;
        m_pc = '0;
        m_instr = 32'h13;
        forever begin
            @(posedge clk);
            r_rst = rst;
            r_ps = pcSrc;
            r_if = en_IF;
            r_req = imem.req;
            r_gnt = imem.gnt;
            r_addr = imem.addr;
            #1;
            if (r_rst) begin
                check("rst_valid", id_valid, 1'b0);
                check("rst_pc", id_pc, 32'h0);
                check("rst_instr", id_instr, 32'h13);
                check("rst_req", imem.req, 1'b0);
                m_v = 1'b0;
                m_pc = '0;
                m_instr = 32'h13;
                delivered = 0;
            end else if (r_ps) begin
                check("redirect_bubble_valid", id_valid, 1'b0);
                check("redirect_bubble_instr", id_instr, 32'h13);
                m_v = 1'b0;
                m_instr = 32'h13;
            end else if (r_if) begin
                if (id_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL stream_underrun: got pc %h expected none", id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("id_pc", id_pc, e);
                        check("id_instr", id_instr, mem(e));
                        m_v = 1'b1;
                        m_pc = e;
                        m_instr = mem(e);
                        delivered++;
                        total_delivered++;
                    end
                end else begin
                    check("bubble_instr", id_instr, 32'h13);
                    m_v = 1'b0;
                    m_instr = 32'h13;
                end
            end else begin
                check("hold_valid", id_valid, m_v);
                check("hold_instr", id_instr, m_instr);
                if (m_v) check("hold_pc", id_pc, m_pc);
            end
            if (p_req && !p_gnt && !p_rst && !r_rst) check("addr_stable", r_addr, p_addr);
            p_req = r_req;
            p_gnt = r_gnt;
            p_rst = r_rst;
            p_addr = r_addr;
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        logic r, ps;
        logic [31:0] bpc;
        int since;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        do_reset();
        repeat (12) step(1, 1, 0, '0, 100, 100, r);
        repeat (6) step(1, 0, 0, '0, 100, 100, r);
        step(1, 1, 0, '0, 100, 100, r);
        check("fifo_full_stall", r, 1'b0);
        repeat (6) step(1, 1, 0, '0, 100, 100, r);
        repeat (2) step(1, 1, 0, '0, 100, 0, r);
        check("two_outstanding", 32'(pend.size()), 32'd2);
        step(1, 1, 1, 32'h0000_0103, 0, 0, r);
        repeat (10) step(1, 1, 0, '0, 100, 100, r);
        repeat (3) step(1, 1, 0, '0, 0, 100, r);
        repeat (6) step(1, 1, 0, '0, 100, 100, r);
        since = 0;
        for (int i = 0; i < 2500; i++) begin
            ps = ($urandom_range(99) < 4) || since > 200;
            bpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step($urandom_range(99) < 85, $urandom_range(99) < 75, ps, bpc, 70, 60, r);
            since = ps ? 0 : since + 1;
            if (i == 1200) begin
                do_reset();
                since = 0;
            end
        end
        repeat (20) step(0, 1, 0, '0, 0, 100, r);
        check("drained", 32'(pend.size()), 32'd0);
        check("progress", total_delivered > 200, 1'b1);
`ifdef IFQ_PERF_CNT_EN
        check("perf_flushed", perf_flushed, 32'(responses - delivered));
        check("perf_fetched_min", perf_fetched >= 32'(delivered), 1'b1);
        check("perf_fetched_max", perf_fetched <= 32'(responses), 1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
